// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader: default widths and FSM state encodings.
package instr_mem_loader_pkg;

    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MEM_DEPTH = 256;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    // States in which the loader takes bytes from the source.
    function automatic logic is_stream_state(input state_t s);
        logic r;
        case (s)
            S_LEN, S_DATA, S_CSUM: r = 1'b1;
            default:               r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_mem_loader_checksum.sv
// 8-bit running-sum accumulator with clear/enable and a compare output.
// Only built when LOADER_CHECKSUM_EN is defined; otherwise this file is empty.
`ifdef LOADER_CHECKSUM_EN
module instr_mem_loader_checksum #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              enable,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] expected,
    output logic              match
);

    logic [DATA_W-1:0] sum_r;

    // Accumulate data bytes modulo 2^DATA_W.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sum_r <= DATA_W'(0);
        end else if (clear) begin
            sum_r <= DATA_W'(0);
        end else if (enable) begin
            sum_r <= sum_r + data;
        end else begin
            sum_r <= sum_r;
        end
    end

    assign match = (sum_r == expected);

endmodule
`endif

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: length-prefixed byte stream -> memory writes at 0..L-1, holds the CPU until done.
// Optional checksum trailer byte enabled by LOADER_CHECKSUM_EN.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] count_r, count_s;
    logic [ADDR_W-1:0] length_r, length_s;

    logic              in_ready_r, in_ready_s;
    logic              wr_en_r, wr_en_s;
    logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
    logic [DATA_W-1:0] wr_data_r, wr_data_s;
    logic              cpu_hold_r, cpu_hold_s;
    logic              done_r, done_s;
    logic              error_r, error_s;

    logic xfer_s;
    logic last_s;

    assign xfer_s = in_valid && in_ready_r;
    assign last_s = (count_r == (length_r - ADDR_W'(1)));

`ifdef LOADER_CHECKSUM_EN
    logic csum_match_s;
    logic csum_clear_s;
    logic csum_enable_s;

    assign csum_clear_s  = (state_s == S_LEN) && (state_r != S_LEN);
    assign csum_enable_s = (state_r == S_DATA) && xfer_s;

    instr_mem_loader_checksum #(
        .DATA_W (DATA_W)
    ) u_checksum (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (csum_clear_s),
        .enable   (csum_enable_s),
        .data     (in_data),
        .expected (in_data),
        .match    (csum_match_s)
    );
`endif

    // State, counter and length registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= S_IDLE;
            count_r  <= ADDR_W'(0);
            length_r <= ADDR_W'(0);
        end else begin
            state_r  <= state_s;
            count_r  <= count_s;
            length_r <= length_s;
        end
    end

    // Next-state, counter and length logic.
    always_comb begin
        state_s  = state_r;
        count_s  = count_r;
        length_s = length_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_LEN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LEN: begin
                if (!xfer_s) begin
                    state_s = S_LEN;
                end else if (in_data == DATA_W'(0)) begin
`ifdef LOADER_CHECKSUM_EN
                    state_s = S_CSUM;
`else
                    state_s = S_DONE;
`endif
                end else if (int'(in_data) > MEM_DEPTH) begin
                    state_s = S_ERR;
                end else begin
                    length_s = ADDR_W'(in_data);
                    count_s  = ADDR_W'(0);
                    state_s  = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer_s) begin
                    count_s = count_r + ADDR_W'(1);
                    if (last_s) begin
`ifdef LOADER_CHECKSUM_EN
                        state_s = S_CSUM;
`else
                        state_s = S_DONE;
`endif
                    end else begin
                        state_s = S_DATA;
                    end
                end else begin
                    state_s = S_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (!xfer_s) begin
                    state_s = S_CSUM;
                end else if (csum_match_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_ERR;
                end
            end
`endif
            S_DONE, S_ERR: begin
                if (start) begin
                    state_s = S_LEN;
                end else begin
                    state_s = state_r;
                end
            end
            // Unreachable encodings park in ERR with the CPU held.
            default: begin
                state_s = S_ERR;
            end
        endcase
    end

    // Next values of the registered outputs; done/error lag state entry by one cycle.
    always_comb begin
        in_ready_s = is_stream_state(state_s);
        wr_en_s    = (state_r == S_DATA) && xfer_s;
        done_s     = (state_r == S_DONE) && (state_s == S_DONE);
        error_s    = (state_r == S_ERR) && (state_s == S_ERR);
        cpu_hold_s = !done_s;
        if (wr_en_s) begin
            wr_addr_s = count_r;
            wr_data_s = in_data;
        end else begin
            wr_addr_s = wr_addr_r;
            wr_data_s = wr_data_r;
        end
    end

    // Output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            in_ready_r <= 1'b0;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= ADDR_W'(0);
            wr_data_r  <= DATA_W'(0);
            cpu_hold_r <= 1'b1;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            in_ready_r <= in_ready_s;
            wr_en_r    <= wr_en_s;
            wr_addr_r  <= wr_addr_s;
            wr_data_r  <= wr_data_s;
            cpu_hold_r <= cpu_hold_s;
            done_r     <= done_s;
            error_r    <= error_s;
        end
    end

    assign in_ready = in_ready_r;
    assign wr_en    = wr_en_r;
    assign wr_addr  = wr_addr_r;
    assign wr_data  = wr_data_r;
    assign cpu_hold = cpu_hold_r;
    assign done     = done_r;
    assign error    = error_r;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader (MEM_DEPTH=16); checksum scenario only with LOADER_CHECKSUM_EN.
module tb_instr_mem_loader;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       cpu_hold;
    logic       done;
    logic       error;

    int tests = 0;
    int fails = 0;

    logic [7:0] addr_log [64];
    logic [7:0] data_log [64];
    int         cyc_log  [64];
    int         wr_cnt = 0;
    int         cyc    = 0;

    instr_mem_loader #(
        .ADDR_W    (8),
        .DATA_W    (8),
        .MEM_DEPTH (16)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record every write strobe seen at a rising edge.
    always @(posedge clock) begin
        cyc = cyc + 1;
        if (wr_en && wr_cnt < 64) begin
            addr_log[wr_cnt] = wr_addr;
            data_log[wr_cnt] = wr_data;
            cyc_log[wr_cnt]  = cyc;
            wr_cnt = wr_cnt + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Present a byte and return at the falling edge after it transfers.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: byte %h never accepted, in_ready=%b required 1", b, in_ready);
        end else begin
            @(negedge clock);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clock);
        tests += 7;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        if (wr_en !== 1'b0) begin fails++; $display("FAIL rst_wr_en: got %b required 0", wr_en); end
        if (wr_addr !== 8'h00) begin fails++; $display("FAIL rst_wr_addr: got %h required 00", wr_addr); end
        if (wr_data !== 8'h00) begin fails++; $display("FAIL rst_wr_data: got %h required 00", wr_data); end
        if (cpu_hold !== 1'b1) begin fails++; $display("FAIL rst_cpu_hold: got %b required 1", cpu_hold); end
        if (done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b required 0", done); end
        if (error !== 1'b0) begin fails++; $display("FAIL rst_error: got %b required 0", error); end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic_load();
        logic [7:0] exp_data [3];
        int base = wr_cnt;
        exp_data[0] = 8'h41; exp_data[1] = 8'h82; exp_data[2] = 8'hC3;
        pulse_start();
        send_byte(8'h03);
        send_byte(8'h41);
        send_byte(8'h82);
        send_byte(8'hC3);
        in_valid = 1'b0;
        check_bit("basic_last_wr_en", wr_en, 1'b1);
        check_bit("basic_done_not_yet", done, 1'b0);
        check_bit("basic_hold_not_yet", cpu_hold, 1'b1);
        @(negedge clock);
        check_bit("basic_done", done, 1'b1);
        check_bit("basic_cpu_hold", cpu_hold, 1'b0);
        check_bit("basic_wr_en_pulse", wr_en, 1'b0);
        check_bit("basic_in_ready_low", in_ready, 1'b0);
        repeat (3) @(negedge clock);
        tests++;
        if (wr_cnt - base !== 3) begin
            fails++;
            $display("FAIL basic_wr_count: got %0d required 3", wr_cnt - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (addr_log[base+i] !== 8'(i) || data_log[base+i] !== exp_data[i]) begin
                    fails++;
                    $display("FAIL basic_write%0d: got (%h,%h) required (%h,%h)", i,
                             addr_log[base+i], data_log[base+i], 8'(i), exp_data[i]);
                end
            end
            tests++;
            if (cyc_log[base+2] - cyc_log[base] !== 2) begin
                fails++;
                $display("FAIL basic_consecutive: got span %0d required 2", cyc_log[base+2] - cyc_log[base]);
            end
        end
    endtask

    task automatic test_len_zero();
        int base = wr_cnt;
        pulse_start();
        check_bit("len0_done_cleared", done, 1'b0);
        check_bit("len0_hold_set", cpu_hold, 1'b1);
        send_byte(8'h00);
        in_valid = 1'b0;
        check_bit("len0_in_ready_drop", in_ready, 1'b0);
        @(negedge clock);
        check_bit("len0_done", done, 1'b1);
        repeat (3) @(negedge clock);
        tests++;
        if (wr_cnt !== base) begin
            fails++;
            $display("FAIL len0_no_writes: got %0d writes required 0", wr_cnt - base);
        end
    endtask

    task automatic test_error_then_recover();
        int base = wr_cnt;
        pulse_start();
        send_byte(8'h20);
        in_valid = 1'b0;
        @(negedge clock);
        check_bit("err_error", error, 1'b1);
        check_bit("err_cpu_hold", cpu_hold, 1'b1);
        check_bit("err_in_ready", in_ready, 1'b0);
        check_bit("err_done", done, 1'b0);
        repeat (2) @(negedge clock);
        pulse_start();
        check_bit("recover_error_cleared", error, 1'b0);
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        check_bit("recover_done", done, 1'b1);
        check_bit("recover_error", error, 1'b0);
        tests++;
        if (wr_cnt - base !== 2 || addr_log[base+1] !== 8'h01 || data_log[base+1] !== 8'h22) begin
            fails++;
            $display("FAIL recover_writes: got count %0d last (%h,%h) required 2 (01,22)",
                     wr_cnt - base, addr_log[base+1], data_log[base+1]);
        end
    endtask

    task automatic test_max_len();
        int base = wr_cnt;
        pulse_start();
        send_byte(8'h10);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i * 3 + 1));
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        check_bit("maxlen_done", done, 1'b1);
        tests++;
        if (wr_cnt - base !== 16 || addr_log[base+15] !== 8'h0F || data_log[base+15] !== 8'h2E) begin
            fails++;
            $display("FAIL maxlen_writes: got count %0d last (%h,%h) required 16 (0f,2e)",
                     wr_cnt - base, addr_log[base+15], data_log[base+15]);
        end
    endtask

    task automatic test_gaps_and_start();
        int base = wr_cnt;
        pulse_start();
        send_byte(8'h04);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hA0 + 8'(i));
            in_valid = 1'b0;
            if (i == 1) begin
                pulse_start();
            end else begin
                @(negedge clock);
            end
        end
        repeat (2) @(negedge clock);
        check_bit("gaps_done", done, 1'b1);
        tests++;
        if (wr_cnt - base !== 4) begin
            fails++;
            $display("FAIL gaps_wr_count: got %0d required 4", wr_cnt - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (addr_log[base+i] !== 8'(i) || data_log[base+i] !== 8'hA0 + 8'(i)) begin
                    fails++;
                    $display("FAIL gaps_write%0d: got (%h,%h) required (%h,%h)", i,
                             addr_log[base+i], data_log[base+i], 8'(i), 8'hA0 + 8'(i));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int base;
        pulse_start();
        send_byte(8'h05);
        send_byte(8'hB0);
        send_byte(8'hB1);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_bit("areset_wr_en", wr_en, 1'b0);
        check_bit("areset_in_ready", in_ready, 1'b0);
        check_bit("areset_cpu_hold", cpu_hold, 1'b1);
        tests++;
        if (wr_addr !== 8'h00 || wr_data !== 8'h00) begin
            fails++;
            $display("FAIL areset_wr_bus: got (%h,%h) required (00,00)", wr_addr, wr_data);
        end
        @(negedge clock);
        reset_n = 1'b1;
        base = wr_cnt;
        // Start with a byte already offered in IDLE: the byte must not be taken.
        @(negedge clock);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h00;
        @(negedge clock);
        start = 1'b0;
        check_bit("simul_in_ready", in_ready, 1'b1);
        check_bit("simul_no_done", done, 1'b0);
        send_byte(8'h01);
        send_byte(8'hD5);
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        check_bit("restart_done", done, 1'b1);
        tests++;
        if (wr_cnt - base !== 1 || addr_log[base] !== 8'h00 || data_log[base] !== 8'hD5) begin
            fails++;
            $display("FAIL restart_write: got count %0d (%h,%h) required 1 (00,d5)",
                     wr_cnt - base, addr_log[base], data_log[base]);
        end
    endtask

    task automatic test_checksum();
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h30);
        in_valid = 1'b0;
        @(negedge clock);
        check_bit("csum_good_done", done, 1'b1);
        check_bit("csum_good_error", error, 1'b0);
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h31);
        in_valid = 1'b0;
        @(negedge clock);
        check_bit("csum_bad_error", error, 1'b1);
        check_bit("csum_bad_done", done, 1'b0);
        check_bit("csum_bad_hold", cpu_hold, 1'b1);
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        in_valid = 1'b0;
        @(negedge clock);
        check_bit("csum_len0_done", done, 1'b1);
    endtask

    initial begin
        test_reset();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`else
        test_basic_load();
        test_len_zero();
        test_error_then_recover();
        test_max_len();
        test_gaps_and_start();
        test_async_reset();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer-side counterpart to the instruction fetch path: accepts a byte stream over a valid/ready handshake and writes it into instruction memory at addresses 0..N-1.
- Holds the processor (`cpu_hold`) until a load completes successfully.
- Sits between an external byte source (host/UART shim) and the instruction memory write port.
- The program counter's reset is qualified by `cpu_hold`.

Parameters:
- ADDR_W, 8, instruction memory address width (matches the 8-bit PC).
- DATA_W, 8, instruction width.
- MEM_DEPTH, 256, number of writable instruction words; a length greater than MEM_DEPTH is an error.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- in_valid  input  1  source has a byte on in_data.
- in_data  input  DATA_W  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- wr_en  output  1  instruction memory write strobe.
- wr_addr  output  ADDR_W  write address.
- wr_data  output  DATA_W  write data.
- cpu_hold  output  1  processor held while high.
- done  output  1  load completed successfully; level signal.
- error  output  1  load failed; level signal.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; cpu_hold=1.
  - in_ready=0, wr_en=0, wr_addr=0, wr_data=0, done=0, error=0.
  - Internal count=0, length=0.
  - A reset mid-load abandons the load immediately. Memory contents already written are not undone.
- Transfer rule: a byte transfers on a rising edge where in_valid=1 and in_ready=1. in_ready is a registered state decode, high only in LEN, DATA and CSUM.
- State IDLE:
  - start=1 -> LEN; done=0, error=0, cpu_hold=1.
- State LEN (first byte = length L, 0..255):
  - L=0 -> DONE, no writes.
  - L>MEM_DEPTH -> ERR.
  - Otherwise length=L, count=0 -> DATA.
- State DATA:
  - On each transfer, the next cycle has wr_en=1, wr_addr=count, wr_data=byte, i.e. one-cycle registered latency.
  - count increments on each transfer.
  - When count reaches length-1 on a transfer -> DONE (or -> CSUM if the optional feature is compiled in).
  - wr_en is a single-cycle pulse per byte. Back-to-back transfers give wr_en high on consecutive cycles.
  - Gaps on in_valid are tolerated indefinitely; there is no timeout.
- State DONE:
  - done=1, cpu_hold=0; these take effect the cycle after the final write strobe is issued.
- State ERR:
  - error=1, cpu_hold=1, in_ready=0.
- start handling:
  - In DONE or ERR: clears done/error, sets cpu_hold=1, -> LEN.
  - In LEN, DATA or CSUM: ignored.
- Address arithmetic is unsigned ADDR_W bits. With MEM_DEPTH=256 and L=255 the last address is 254. Address 255 is never written; it is reserved.
- Simultaneous start and in_valid in IDLE: start is taken; the byte is not accepted because in_ready=0 that cycle.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last data byte, state CSUM accepts one more byte.
  - The loader keeps an 8-bit running sum (mod 256) of the data bytes only.
  - Match -> DONE. Mismatch -> ERR.
  - For L=0 the checksum byte is still required and must equal 0x00.
- Undefined:
  - No CSUM state; DATA goes directly to DONE.
  - No checksum hardware.

Decomposition:
- Shared header loader_defs.vh holds:
  - State encodings: IDLE=0, LEN=1, DATA=2, CSUM=3, DONE=4, ERR=5 (3-bit).
  - Default widths.
- Natural sub-module: load_checksum, the 8-bit accumulator with clear/enable and compare output. Instantiated only under LOADER_CHECKSUM_EN.
- FSM and counter stay in the top module.

Test Plan:
- Reset then start, stream 0x03,0x41,0x82,0xC3 back-to-back -> writes (0,0x41),(1,0x82),(2,0xC3) on 3 consecutive wr_en cycles; done=1, cpu_hold=0 the cycle after.
- Length 0x00 (checksum off) -> no wr_en; done=1; in_ready drops.
- MEM_DEPTH=16, length 0x20 -> error=1, cpu_hold=1, no writes; then start + valid stream -> clean load, error=0.
- in_valid toggled every other cycle during a 4-byte load, plus start pulsed mid-DATA -> exactly 4 writes to addresses 0..3; start ignored.
- reset_n=0 asynchronously after 2 of 5 bytes -> outputs at reset values within the same cycle; next load restarts at wr_addr=0.
- LOADER_CHECKSUM_EN: stream 0x02,0x10,0x20,0x30 -> done; same data with checksum 0x31 -> error=1.
